// File: rtl/ram_pkg.sv
// Shared definitions for the dual-port RAM with clear sequencer.
package ram_pkg;

    // Controller states: sweeping the array to INIT_VAL, or serving ports.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Same-address read-during-write behaviour selectors.
    localparam int RDW_READ_OLD    = 0;
    localparam int RDW_WRITE_FIRST = 1;

endpackage

// File: rtl/ram_clr_seq.sv
// Clear sequencer: walks every address writing INIT_VAL after reset or on
// a clr request, and flags busy while the sweep is running.
module ram_clr_seq
    import ram_pkg::*;
#(
    parameter int              ADDR_W   = 2,
    parameter int              DATA_W   = 8,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic [DATA_W-1:0] clr_data
);

    localparam logic [ADDR_W-1:0] PTR_LAST = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    // State and sweep pointer registers; reset always restarts a full sweep.
    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state and pointer: clr always restarts the sweep from address 0.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latch).
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr) begin
                    ptr_d = '0;
                end else if (ptr_q == PTR_LAST) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: begin
                if (clr) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
        endcase
    end

    // Outputs decoded from state; no memory write while reset is held.
    always_comb begin
        busy     = (state_q == ST_CLEAR);
        clr_we   = busy & ~rst;
        clr_addr = ptr_q;
        clr_data = INIT_VAL;
    end

endmodule

// File: rtl/ram_dp_clr.sv
// Simple dual-port RAM (one write, one registered read port) with a
// selectable read-during-write policy and a built-in clear sweep.
module ram_dp_clr
    import ram_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 2,
    parameter logic [DATA_W-1:0] INIT_VAL = '0,
    parameter int                RDW_MODE = RDW_READ_OLD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] clr_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] rd_next;

    ram_clr_seq #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .INIT_VAL (INIT_VAL)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .clr_data (clr_data)
    );

    // Write-port mux: the sweep owns the port while busy, user port otherwise.
    always_comb begin
        mem_we   = clr_we | (wr_en & ~busy & ~rst);
        mem_addr = busy ? clr_addr : wr_addr;
        mem_din  = busy ? clr_data : wr_data;
    end

    // Storage array write.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; the clear sweep initialises it instead.
        if (mem_we) begin
            mem[mem_addr] <= mem_din;
        end
    end

    // Read source: bypass write data on same-address collision in write-first mode.
    always_comb begin
        rd_next = mem[rd_addr];
        if (RDW_MODE == RDW_WRITE_FIRST && wr_en && (wr_addr == rd_addr)) begin
            rd_next = wr_data;
        end
    end

    // Registered read data and one-cycle valid; ports ignored while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (busy) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_next;
            end
        end
    end

endmodule

// File: tb/tb_ram_dp_clr.sv
// Bench for ram_dp_clr: two instances (read-old and write-first) share one
// stimulus stream; a reference model predicts reads into per-instance
// scoreboards that a negedge monitor drains.
module tb_ram_dp_clr;

    localparam int         DW    = 8;
    localparam int         AW    = 2;
    localparam int         DEPTH = 1 << AW;
    localparam logic [7:0] INIT  = 8'hA5;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, clr, wr_en, rd_en;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data0, rd_data1;
    logic          rd_valid0, rd_valid1, busy0, busy1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state.
    logic [7:0] model_mem [DEPTH];
    logic [7:0] model_rd  [2];
    int         clear_left = 0;
    bit         have_reset = 0;
    exp_t       sb [2][$];

    ram_dp_clr #(.DATA_W(DW), .ADDR_W(AW), .INIT_VAL(INIT), .RDW_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .busy(busy0));

    ram_dp_clr #(.DATA_W(DW), .ADDR_W(AW), .INIT_VAL(INIT), .RDW_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .busy(busy1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rd_valid must match the oldest predicted read, on time.
    task automatic monitor(input int k, input logic v, input logic [7:0] d);
        exp_t e;
        if (v === 1'b1) begin
            if (sb[k].size() == 0) begin
                check($sformatf("spurious_rd_valid_%0d", k), 1, 0);
            end else begin
                e = sb[k].pop_front();
                check($sformatf("rd_data_%0d", k), {24'd0, d}, {24'd0, e.data});
                check($sformatf("rd_latency_%0d", k), cyc, e.due);
            end
        end else if (sb[k].size() > 0 && sb[k][0].due <= cyc) begin
            e = sb[k].pop_front();
            check($sformatf("missing_rd_valid_%0d", k), 0, 1);
        end
    endtask

    always @(negedge clk) begin
        monitor(0, rd_valid0, rd_data0);
        monitor(1, rd_valid1, rd_data1);
    end

    // Present one cycle of inputs, advance the model, cross the edge.
    task automatic step(input logic r, input logic c, input logic we, input logic [1:0] wa,
                        input logic [7:0] wd, input logic re, input logic [1:0] ra);
        logic [7:0] old_v, wf_v;
        rst = r; clr = c; wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
        if (have_reset) begin
            check("busy_0", {31'd0, busy0}, {31'd0, clear_left > 0});
            check("busy_1", {31'd0, busy1}, {31'd0, clear_left > 0});
        end
        if (r) begin
            clear_left  = DEPTH;
            model_rd[0] = 8'h00;
            model_rd[1] = 8'h00;
        end else if (clear_left > 0) begin
            clear_left = c ? DEPTH : clear_left - 1;
            if (clear_left == 0) begin
                for (int i = 0; i < DEPTH; i++) model_mem[i] = INIT;
            end
        end else begin
            if (re) begin
                old_v = model_mem[ra];
                wf_v  = (we && wa == ra) ? wd : model_mem[ra];
                sb[0].push_back('{old_v, cyc + 1});
                sb[1].push_back('{wf_v, cyc + 1});
                model_rd[0] = old_v;
                model_rd[1] = wf_v;
            end
            if (we) model_mem[wa] = wd;
            if (c) clear_left = DEPTH;
        end
        @(posedge clk);
        #1;
        if (r) have_reset = 1;
        if (have_reset) begin
            check("rd_data_hold_0", {24'd0, rd_data0}, {24'd0, model_rd[0]});
            check("rd_data_hold_1", {24'd0, rd_data1}, {24'd0, model_rd[1]});
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 2'd0, 8'h00, 0, 2'd0);
    endtask

    // Count remaining busy cycles with a bounded loop.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 20 && busy0 === 1'b1; i++) begin
            n++;
            step(0, 0, $urandom_range(0, 1), 2'($urandom), 8'($urandom), 0, 2'($urandom));
        end
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) step(0, 0, 0, 2'd0, 8'h00, 1, 2'(a));
        idle();
    endtask

    initial begin
        int n;
        rst = 1; clr = 0; wr_en = 0; wr_addr = '0; wr_data = '0; rd_en = 0; rd_addr = '0;

        // 1. Reset then sweep: busy for exactly DEPTH cycles, contents INIT.
        step(1, 0, 0, 2'd0, 8'h00, 0, 2'd0);
        step(1, 0, 0, 2'd0, 8'h00, 0, 2'd0);
        check("reset_rd_valid", {31'd0, rd_valid0 | rd_valid1}, 0);
        check("reset_busy", {31'd0, busy0 & busy1}, 1);
        count_busy(n);
        check("busy_after_reset", n, DEPTH);
        read_all();

        // 2. Write 11..44, read back in reverse, back-to-back.
        step(0, 0, 1, 2'd0, 8'h11, 0, 2'd0);
        step(0, 0, 1, 2'd1, 8'h22, 0, 2'd0);
        step(0, 0, 1, 2'd2, 8'h33, 0, 2'd0);
        step(0, 0, 1, 2'd3, 8'h44, 0, 2'd0);
        for (int a = 3; a >= 0; a--) step(0, 0, 0, 2'd0, 8'h00, 1, 2'(a));
        idle();

        // 3. Same-address collision on addr 2, then plain re-read.
        step(0, 0, 1, 2'd2, 8'h22, 0, 2'd0);
        step(0, 0, 1, 2'd2, 8'h5A, 1, 2'd2);
        step(0, 0, 0, 2'd0, 8'h00, 1, 2'd2);
        idle();

        // 4. clr together with a write; ports ignored while busy.
        step(0, 1, 1, 2'd1, 8'h77, 0, 2'd0);
        count_busy(n);
        check("busy_after_clr", n, DEPTH);
        read_all();

        // 5. clr on the 3rd busy cycle restarts the sweep: 3 + DEPTH busy cycles.
        step(0, 0, 1, 2'd3, 8'h99, 0, 2'd0);
        step(0, 1, 0, 2'd0, 8'h00, 0, 2'd0);
        idle();
        idle();
        step(0, 1, 0, 2'd0, 8'h00, 0, 2'd0);
        count_busy(n);
        check("busy_clr_in_sweep", n + 3, 3 + DEPTH);
        read_all();

        // 6. Reset on the 2nd busy cycle.
        step(0, 0, 0, 2'd0, 8'h00, 1, 2'd1);
        step(0, 1, 0, 2'd0, 8'h00, 0, 2'd0);
        idle();
        step(1, 0, 0, 2'd0, 8'h00, 0, 2'd0);
        check("mid_sweep_rst_rd_valid", {31'd0, rd_valid0 | rd_valid1}, 0);
        check("mid_sweep_rst_rd_data", {16'd0, rd_data0, rd_data1}, 0);
        count_busy(n);
        check("busy_after_mid_rst", n, DEPTH);
        read_all();

        // Random traffic with occasional clr and reset.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 1), 2'($urandom), 8'($urandom),
                 $urandom_range(0, 1), 2'($urandom));
        end
        for (int i = 0; i < DEPTH + 2; i++) idle();
        read_all();
        idle();

        check("scoreboard_drained_0", sb[0].size(), 0);
        check("scoreboard_drained_1", sb[1].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
